ps2_keyboard_receiver: RTL and testbench
========================================

Name: ps2_keyboard_receiver

Overview:
Player-input front end for the game: the input direction, complementing the VGA output path. It receives PS/2 keyboard frames on the raw ps2_clk/ps2_data lines and decodes make, break and extended prefixes. It outputs one-cycle scan-code events plus level-held left/right/fire key states for the object and game logic. It runs in the 50 MHz system domain.

Parameters:
FILTER_LEN, 8, consecutive equal samples required before a filtered ps2_clk level change is accepted.
TIMEOUT_CYCLES, 100000, idle clocks (2 ms at 50 MHz) after which a partial frame is discarded.

Ports:
clk  input  1  system clock (50 MHz)
rst  input  1  asynchronous, active-low reset
ps2_clk  input  1  raw keyboard clock (asynchronous, open-collector)
ps2_data  input  1  raw keyboard data (asynchronous)
scan_code  output  8  last decoded non-prefix byte
code_valid  output  1  one-cycle pulse: scan_code, is_break and is_extended valid
is_break  output  1  code was preceded by F0
is_extended  output  1  code was preceded by E0
frame_error  output  1  one-cycle pulse on parity, start, stop or timeout error
key_left  output  1  level: E0 6B held
key_right  output  1  level: E0 74 held
key_fire  output  1  level: 29 (space) held

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst=0 resets immediately). All outputs 0, FSM IDLE, prefix flags clear, synchronizers preset to 1.
- Input conditioning: ps2_clk and ps2_data each pass through 2 flops. Filtered ps2_clk changes only after FILTER_LEN identical synced samples. A falling edge of filtered clk produces a one-cycle fall strobe. Data is sampled on the strobe from the synced ps2_data.
- Frame format: start(0), 8 data bits LSB first, odd parity, stop(1).
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall, if data=0 go to DATA with bit count 0. Otherwise stay in IDLE and pulse frame_error.
  - DATA: shift in on each fall. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit and go to STOP.
  - STOP: on fall, go to IDLE. If stop=1 and the XOR of 8 data bits and parity is 1, the frame is good. Otherwise pulse frame_error.
- Timeout: a watchdog counts clocks since the last fall while not in IDLE. Reaching TIMEOUT_CYCLES forces IDLE, pulses frame_error and clears prefix flags.
- Good byte E0: set ext flag, no code_valid.
- Good byte F0: set brk flag, no code_valid.
- Any other good byte:
  - Cycle after the stop-bit strobe: scan_code=byte, is_break=brk, is_extended=ext, code_valid=1 for exactly one cycle. Then both flags clear.
  - key updates in the same cycle: key_left/key_right only when ext=1; key_fire only when ext=0. Set on make, cleared on break.
- scan_code, is_break and is_extended hold until the next code_valid.
- Any frame_error clears the prefix flags; key levels are unchanged.
- Repeat make codes (typematic) re-pulse code_valid; the key level stays 1.
- A frame_error and a code_valid never occur in the same cycle.
- rst asserted mid-frame: immediate return to reset state; the partial frame is discarded.

Decomposition:
- Shared package ps2_pkg: FSM state encoding, constants PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BRK=8'hF0, KEY_LEFT=8'h6B, KEY_RIGHT=8'h74, KEY_FIRE=8'h29.
- Sub-module ps2_input_filter: 2-flop synchronizers plus clk glitch filter, outputs synced data and fall strobe. Instanced once.

Test Plan:
- Frame 0x1C (data bits 0,0,1,1,1,0,0,0; parity 0; stop 1) -> code_valid 1 cycle, scan_code=1C, is_break=0, is_extended=0.
- Frames F0, 1C -> single code_valid, scan_code=1C, is_break=1; no pulse after F0.
- Frames E0 6B then E0 F0 6B -> key_left 0->1 then 1->0, is_extended=1 both times; key_right and key_fire stay 0.
- Frame 0x1C with parity 1 -> frame_error pulse, no code_valid; a following good 0x29 sets key_fire=1.
- Four bits then silence for TIMEOUT_CYCLES+10 -> frame_error pulse, FSM IDLE; the next full 0x74 frame decodes correctly.
- 1-cycle glitches on ps2_clk (shorter than FILTER_LEN) during a frame -> no extra bits, correct byte decoded. rst low mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM encoding, protocol
// prefix bytes, game key scan codes and the frame validity check.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    localparam logic [7:0] KEY_LEFT       = 8'h6B;
    localparam logic [7:0] KEY_RIGHT      = 8'h74;
    localparam logic [7:0] KEY_FIRE       = 8'h29;

    // A frame is good when the stop bit is 1 and data plus parity has odd weight.
    function automatic logic frame_ok(input logic [7:0] data,
                                      input logic       parity,
                                      input logic       stop);
        return stop & ((^data) ^ parity);
    endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// Input conditioning for the raw PS/2 lines: two-flop synchronizers on both
// lines, a glitch filter on the clock line and a falling-edge strobe.
module ps2_input_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_sync,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync_reg;
    logic [1:0]    data_sync_reg;
    logic          filt_reg;
    logic [CW-1:0] cnt_reg;
    logic          fall_reg;

    // Synchronize both lines; the filtered clock flips only after FILTER_LEN
    // consecutive samples disagree with it, and a 1->0 flip emits the strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_reg  <= 2'b11;
            data_sync_reg <= 2'b11;
            filt_reg      <= 1'b1;
            cnt_reg       <= '0;
            fall_reg      <= 1'b0;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
            data_sync_reg <= {data_sync_reg[0], ps2_data};
            fall_reg      <= 1'b0;
            if (clk_sync_reg[1] == filt_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CW'(FILTER_LEN - 1)) begin
                filt_reg <= clk_sync_reg[1];
                cnt_reg  <= '0;
                fall_reg <= filt_reg;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign data_sync = data_sync_reg[1];
    assign fall      = fall_reg;

endmodule

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard receiver: frames bytes from the conditioned PS/2 lines,
// tracks E0/F0 prefixes, emits scan-code events and held game key levels.
module ps2_keyboard_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic       frame_error,
    output logic       key_left,
    output logic       key_right,
    output logic       key_fire
);

    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    logic data_s;
    logic fall;

    ps2_state_t    state_reg, state_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic [7:0]    data_reg, data_next;
    logic          parity_reg, parity_next;
    logic [WW-1:0] wdog_reg, wdog_next;
    logic          ext_reg, ext_next;
    logic          brk_reg, brk_next;
    logic [7:0]    scan_code_reg, scan_code_next;
    logic          is_break_reg, is_break_next;
    logic          is_extended_reg, is_extended_next;
    logic          code_valid_reg, code_valid_next;
    logic          frame_error_reg, frame_error_next;
    logic          key_left_reg, key_left_next;
    logic          key_right_reg, key_right_next;
    logic          key_fire_reg, key_fire_next;

    ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .data_sync (data_s),
        .fall      (fall)
    );

    // State register for the frame FSM, prefix flags and all outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            bit_cnt_reg     <= '0;
            data_reg        <= '0;
            parity_reg      <= 1'b0;
            wdog_reg        <= '0;
            ext_reg         <= 1'b0;
            brk_reg         <= 1'b0;
            scan_code_reg   <= '0;
            is_break_reg    <= 1'b0;
            is_extended_reg <= 1'b0;
            code_valid_reg  <= 1'b0;
            frame_error_reg <= 1'b0;
            key_left_reg    <= 1'b0;
            key_right_reg   <= 1'b0;
            key_fire_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            bit_cnt_reg     <= bit_cnt_next;
            data_reg        <= data_next;
            parity_reg      <= parity_next;
            wdog_reg        <= wdog_next;
            ext_reg         <= ext_next;
            brk_reg         <= brk_next;
            scan_code_reg   <= scan_code_next;
            is_break_reg    <= is_break_next;
            is_extended_reg <= is_extended_next;
            code_valid_reg  <= code_valid_next;
            frame_error_reg <= frame_error_next;
            key_left_reg    <= key_left_next;
            key_right_reg   <= key_right_next;
            key_fire_reg    <= key_fire_next;
        end
    end

    // Next-state logic: bit framing on each fall strobe, byte decode on the
    // stop bit, and a watchdog that abandons a stalled partial frame.
    always_comb begin
        state_next       = state_reg;
        bit_cnt_next     = bit_cnt_reg;
        data_next        = data_reg;
        parity_next      = parity_reg;
        wdog_next        = wdog_reg;
        ext_next         = ext_reg;
        brk_next         = brk_reg;
        scan_code_next   = scan_code_reg;
        is_break_next    = is_break_reg;
        is_extended_next = is_extended_reg;
        code_valid_next  = 1'b0;
        frame_error_next = 1'b0;
        key_left_next    = key_left_reg;
        key_right_next   = key_right_reg;
        key_fire_next    = key_fire_reg;

        case (state_reg)
            ST_IDLE: begin
                wdog_next = '0;
                if (fall) begin
                    if (!data_s) begin
                        state_next   = ST_DATA;
                        bit_cnt_next = '0;
                    end else begin
                        frame_error_next = 1'b1;
                        ext_next         = 1'b0;
                        brk_next         = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (fall) begin
                    data_next    = {data_s, data_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    parity_next = data_s;
                    state_next  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_next = ST_IDLE;
                    if (frame_ok(data_reg, parity_reg, data_s)) begin
                        if (data_reg == PS2_PREFIX_EXT) begin
                            ext_next = 1'b1;
                        end else if (data_reg == PS2_PREFIX_BRK) begin
                            brk_next = 1'b1;
                        end else begin
                            scan_code_next   = data_reg;
                            is_break_next    = brk_reg;
                            is_extended_next = ext_reg;
                            code_valid_next  = 1'b1;
                            ext_next         = 1'b0;
                            brk_next         = 1'b0;
                            if (ext_reg) begin
                                if (data_reg == KEY_LEFT)  key_left_next  = !brk_reg;
                                if (data_reg == KEY_RIGHT) key_right_next = !brk_reg;
                            end else if (data_reg == KEY_FIRE) begin
                                key_fire_next = !brk_reg;
                            end
                        end
                    end else begin
                        frame_error_next = 1'b1;
                        ext_next         = 1'b0;
                        brk_next         = 1'b0;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Watchdog only acts between strobes, so it never collides with a decode.
        if (state_reg != ST_IDLE) begin
            if (fall) begin
                wdog_next = '0;
            end else if (wdog_reg == WW'(TIMEOUT_CYCLES - 1)) begin
                wdog_next        = '0;
                state_next       = ST_IDLE;
                frame_error_next = 1'b1;
                ext_next         = 1'b0;
                brk_next         = 1'b0;
            end else begin
                wdog_next = wdog_reg + WW'(1);
            end
        end
    end

    assign scan_code   = scan_code_reg;
    assign code_valid  = code_valid_reg;
    assign is_break    = is_break_reg;
    assign is_extended = is_extended_reg;
    assign frame_error = frame_error_reg;
    assign key_left    = key_left_reg;
    assign key_right   = key_right_reg;
    assign key_fire    = key_fire_reg;

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Self-checking bench for ps2_keyboard_receiver: expected events are queued as
// frames are driven and compared when code_valid/frame_error pulse.
module tb_ps2_keyboard_receiver;

    localparam int TB_TIMEOUT = 2000;
    localparam int QTR        = 10;   // quarter of a PS/2 bit period, in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scan_code;
    logic       code_valid, is_break, is_extended, frame_error;
    logic       key_left, key_right, key_fire;

    typedef struct packed {
        logic       is_err;
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    ps2_keyboard_receiver #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .scan_code   (scan_code),
        .code_valid  (code_valid),
        .is_break    (is_break),
        .is_extended (is_extended),
        .frame_error (frame_error),
        .key_left    (key_left),
        .key_right   (key_right),
        .key_fire    (key_fire)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && (code_valid || frame_error)) begin
            checks++;
            if (code_valid && frame_error) begin
                errors++;
                $display("FAIL pulse_overlap code_valid=1 frame_error=1 required exclusive");
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event code_valid=%0b frame_error=%0b scan_code=%h",
                         code_valid, frame_error, scan_code);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.is_err) begin
                    if (!frame_error) begin
                        errors++;
                        $display("FAIL event_kind got code %h required frame_error", scan_code);
                    end else begin
                        $display("event frame_error");
                    end
                end else if (!code_valid || scan_code !== mon_e.code ||
                             is_break !== mon_e.brk || is_extended !== mon_e.ext) begin
                    errors++;
                    $display("FAIL code_event got cv=%0b code=%h brk=%0b ext=%0b required code=%h brk=%0b ext=%0b",
                             code_valid, scan_code, is_break, is_extended,
                             mon_e.code, mon_e.brk, mon_e.ext);
                end else begin
                    $display("event code=%h brk=%0b ext=%0b", scan_code, is_break, is_extended);
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One PS/2 bit: data set while clock high, then a low phase; optional
    // one-cycle glitches inside both phases.
    task automatic send_bit(input logic b, input bit glitch);
        ps2_data = b;
        wait_clk(QTR);
        if (glitch) begin ps2_clk = 1'b0; wait_clk(1); ps2_clk = 1'b1; end
        wait_clk(QTR);
        ps2_clk = 1'b0;
        wait_clk(QTR);
        if (glitch) begin ps2_clk = 1'b1; wait_clk(1); ps2_clk = 1'b0; end
        wait_clk(QTR);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input bit bad_stop, input bit glitch);
        send_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
        send_bit((~^b) ^ bad_par, glitch);
        send_bit(!bad_stop, glitch);
        ps2_data = 1'b1;
        wait_clk(30);
    endtask

    task automatic send_partial(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) send_bit((i == 0) ? 1'b0 : b[i-1], 1'b0);
        ps2_data = 1'b1;
    endtask

    task automatic push_code(input logic [7:0] c, input logic brk, input logic ext);
        exp_t e;
        e = '{is_err: 1'b0, code: c, brk: brk, ext: ext};
        sb.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e = '{is_err: 1'b1, code: 8'h00, brk: 1'b0, ext: 1'b0};
        sb.push_back(e);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s pending=%0d required 0", name, sb.size());
            sb.delete();
        end else begin
            $display("%s all expected events seen", name);
        end
    endtask

    task automatic check_keys(input string name, input logic [2:0] exp_keys);
        checks++;
        if ({key_left, key_right, key_fire} !== exp_keys) begin
            errors++;
            $display("FAIL %s keys(l,r,f) got %b required %b", name,
                     {key_left, key_right, key_fire}, exp_keys);
        end else begin
            $display("%s keys=%b", name, exp_keys);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({scan_code, code_valid, is_break, is_extended, frame_error,
             key_left, key_right, key_fire} !== 15'd0) begin
            errors++;
            $display("FAIL %s outputs got %h/%b%b%b%b%b%b%b required all 0", name,
                     scan_code, code_valid, is_break, is_extended, frame_error,
                     key_left, key_right, key_fire);
        end else begin
            $display("%s outputs all 0", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        wait_clk(3);
        check_all_zero("reset_held");
        rst = 1'b1;
        wait_clk(20);
        check_all_zero("reset_released");
    endtask

    task automatic test_make();
        push_code(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 0, 0, 0);
        check_drained("make_1C");
        checks++;
        if (scan_code !== 8'h1C || code_valid !== 1'b0) begin
            errors++;
            $display("FAIL make_hold got code=%h cv=%0b required 1C/0", scan_code, code_valid);
        end else begin
            $display("make_hold code=1C");
        end
    endtask

    task automatic test_break();
        push_code(8'h1C, 1'b1, 1'b0);
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h1C, 0, 0, 0);
        check_drained("break_1C");
        checks++;
        if (is_break !== 1'b1) begin
            errors++;
            $display("FAIL break_hold is_break got %0b required 1", is_break);
        end else begin
            $display("break_hold is_break=1");
        end
    endtask

    task automatic test_keys();
        push_code(8'h6B, 1'b0, 1'b1);
        send_frame(8'hE0, 0, 0, 0);
        send_frame(8'h6B, 0, 0, 0);
        check_drained("left_make");
        check_keys("left_make", 3'b100);
        push_code(8'h6B, 1'b1, 1'b1);
        send_frame(8'hE0, 0, 0, 0);
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h6B, 0, 0, 0);
        check_drained("left_break");
        check_keys("left_break", 3'b000);
    endtask

    task automatic test_parity_error();
        push_err();
        send_frame(8'h1C, 1, 0, 0);
        check_drained("parity_error");
        check_keys("parity_error", 3'b000);
        push_code(8'h29, 1'b0, 1'b0);
        send_frame(8'h29, 0, 0, 0);
        check_drained("fire_make");
        check_keys("fire_make", 3'b001);
        // typematic repeat
        push_code(8'h29, 1'b0, 1'b0);
        send_frame(8'h29, 0, 0, 0);
        check_drained("fire_repeat");
        check_keys("fire_repeat", 3'b001);
        // an error after E0 drops the prefix; the following 29 is plain
        push_err();
        push_code(8'h29, 1'b1, 1'b0);
        send_frame(8'hE0, 0, 0, 0);
        send_frame(8'h1C, 1, 0, 0);
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h29, 0, 0, 0);
        check_drained("fire_break_after_error");
        check_keys("fire_break_after_error", 3'b000);
    endtask

    task automatic test_stop_error();
        push_err();
        send_frame(8'h74, 0, 1, 0);
        check_drained("stop_error");
        check_keys("stop_error", 3'b000);
    endtask

    task automatic test_timeout();
        push_err();
        send_partial(8'h74, 4);
        wait_clk(TB_TIMEOUT + 10);
        check_drained("timeout");
        push_code(8'h74, 1'b0, 1'b0);
        send_frame(8'h74, 0, 0, 0);
        check_drained("after_timeout_74");
        check_keys("after_timeout_74", 3'b000);
    endtask

    task automatic test_glitch();
        push_code(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 0, 0, 1);
        check_drained("glitch_1C");
        push_code(8'h74, 1'b0, 1'b1);
        send_frame(8'hE0, 0, 0, 1);
        send_frame(8'h74, 0, 0, 1);
        check_drained("glitch_right");
        check_keys("glitch_right", 3'b010);
    endtask

    task automatic test_reset_midframe();
        push_code(8'h29, 1'b0, 1'b0);
        send_frame(8'h29, 0, 0, 0);
        check_drained("fire_before_reset");
        send_partial(8'h1C, 3);
        rst = 1'b0;
        #1;
        check_all_zero("reset_midframe");
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_clk(5);
        rst = 1'b1;
        wait_clk(20);
        check_drained("reset_midframe_quiet");
        push_code(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 0, 0, 0);
        check_drained("after_reset_1C");
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_keys();
        test_parity_error();
        test_stop_error();
        test_timeout();
        test_glitch();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
